addr8s_sat_accum: RTL and testbench
===================================

Name: addr8s_sat_accum

Overview:
- Sequential stage wrapped around the 8-bit signed adder datapath. Accepts a valid/ready stream of signed 8-bit operands and accumulates each burst with saturation.
- Each step takes the 9-bit signed adder result, clamps it back to 8 bits, and registers it as the new accumulator.
- The final burst sum is presented on a valid/ready output port to the downstream consumer.

Parameters:
- DATA_W, 8, operand/accumulator width (signed two's complement); adder result is DATA_W+1.
- MAX_LEN, 15, maximum beats per burst before forced termination; range 1..255.
- CNT_W, 8, width of the beat counter and out_count; must satisfy 2**CNT_W > MAX_LEN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  DATA_W  signed operand.
- in_last  input  1  final beat of burst.
- out_valid  output  1  burst result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  DATA_W  saturated signed burst sum.
- out_ovf  output  1  saturation occurred at least once in this burst.
- out_trunc  output  1  burst ended by MAX_LEN, not in_last.
- out_count  output  CNT_W  beats accumulated in burst.
- out_fault  output  1  redundant-adder mismatch seen in burst (see Optional Feature).

Behaviour:
- Reset is asynchronous, active-low; one clock. On rst_n=0: state=IDLE; acc=0; count=0; out_valid=0; out_data=0; out_ovf=0; out_trunc=0; out_count=0; out_fault=0.
- Reset mid-burst discards the partial sum; no output is produced.
- in_ready = (state != HOLD). A beat is accepted when in_valid && in_ready.
- FSM states:
  - IDLE: on accept, acc <= in_data; count <= 1; ovf <= 0. If in_last or MAX_LEN==1, go to HOLD; else go to ACC.
  - ACC: on accept, sum9 = sext(acc) + sext(in_data); acc <= sat(sum9); count <= count+1; ovf |= clamp occurred. Go to HOLD if in_last or count+1==MAX_LEN, else stay in ACC.
  - HOLD: out_valid=1. Outputs are stable until out_ready. On out_ready, go to IDLE; out_valid drops next cycle.
- Saturation: sum9 > 2**(DATA_W-1)-1 gives +127; sum9 < -2**(DATA_W-1) gives -128; otherwise the low DATA_W bits.
- out_data, out_ovf, out_trunc, out_count are registered on HOLD entry.
- out_trunc=1 only when the MAX_LEN limit ends the burst with in_last=0. If in_last=1 arrives on the MAX_LEN beat, out_trunc=0.
- Latency: out_valid rises the cycle after the terminating beat is accepted.
- Throughput: one beat/cycle; one bubble per burst (HOLD blocks input).
- No input is accepted in the same cycle as the output handshake.
- in_data and in_last are ignored when in_valid=0; idle cycles inside a burst are allowed.

Optional Feature:
- Macro ADDR8S_FAULT_CHK_EN.
- Defined: a second, independently coded 9-bit adder computes sum9 in parallel. Any mismatch on an accepted ACC beat sets a sticky per-burst fault flag, captured to out_fault on HOLD entry; the flag is cleared on IDLE accept.
- Not defined: no redundant adder; out_fault is tied to 0.

Decomposition:
- Shared package addr8s_pkg holds:
  - DATA_W default;
  - SAT_MAX/SAT_MIN constants;
  - FSM state enum {IDLE, ACC, HOLD};
  - function sat9to8.
- One natural sub-module: addr8s_sat_step, a combinational sign-extend, add and clamp that returns {sat_data, ovf}. It is instantiated twice when the fault check is enabled.

Test Plan:
- Burst 10, 20, -5 (last on -5), out_ready=1 -> out_data=25, out_ovf=0, out_trunc=0, out_count=3; out_valid one cycle after last beat.
- Burst 100, 100, -50 (last) -> step 2 clamps to 127; final 77; out_ovf=1.
- Burst -100, -100 (last) -> out_data=-128, out_ovf=1.
- MAX_LEN=15: 16 beats of 1, in_last never set -> first result out_data=15, out_count=15, out_trunc=1. The 16th beat starts a new burst only after the result handshake.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> in_ready=0 and outputs stable throughout; after out_ready=1, in_ready=1 next cycle.
- Reset mid-burst after 2 beats -> outputs immediately 0. Next burst 7 (last) -> out_data=7, out_count=1.
- With ADDR8S_FAULT_CHK_EN and one adder forced faulty on one beat -> out_fault=1 for that burst only.

Source files
------------

// File: rtl/addr8s_pkg.sv
// Shared types, constants and clamp helper for the saturating 8-bit signed accumulator.
package addr8s_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Clamp a DATA_W+1 signed sum back to DATA_W bits; returns {ovf, data}.
  function automatic logic [DATA_W:0] sat9to8(input logic [DATA_W:0] sum);
    logic [DATA_W:0] res;
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      res = {1'b1, (sum[DATA_W] ? SAT_MIN : SAT_MAX)};
    end else begin
      res = {1'b0, sum[DATA_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/addr8s_sat_step.sv
// Combinational sign-extend, add and clamp. ALT selects an independently coded
// adder (unsigned add plus reconstructed sign) used as the redundant check copy.
module addr8s_sat_step #(
  parameter int unsigned DATA_W = addr8s_pkg::DATA_W,
  parameter bit          ALT    = 1'b0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sat,
  output logic              ovf
);
  import addr8s_pkg::*;

  logic [DATA_W:0] sum_w;

  if (ALT) begin : g_alt
    logic [DATA_W:0] raw;
    assign raw   = {1'b0, a} + {1'b0, b};
    // Sign of the extended sum = sign(a) ^ sign(b) ^ carry out of the top data bit.
    assign sum_w = {a[DATA_W-1] ^ b[DATA_W-1] ^ raw[DATA_W], raw[DATA_W-1:0]};
  end else begin : g_ref
    assign sum_w = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  end

  if (DATA_W == addr8s_pkg::DATA_W) begin : g_pkg_clamp
    assign {ovf, sat} = sat9to8(sum_w);
  end else begin : g_gen_clamp
    assign ovf = sum_w[DATA_W] ^ sum_w[DATA_W-1];
    assign sat = ovf ? {sum_w[DATA_W], {(DATA_W-1){~sum_w[DATA_W]}}}
                     : sum_w[DATA_W-1:0];
  end

endmodule

// File: rtl/addr8s_sat_accum.sv
// Burst accumulator with saturation over a valid/ready stream.
// Optional redundant-adder check enabled by defining ADDR8S_FAULT_CHK_EN.
module addr8s_sat_accum #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_LEN = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic              out_trunc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_fault
);
  import addr8s_pkg::*;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d, count_inc;
  logic               ovf_q, ovf_d;
  logic               fault_q, fault_d;
  logic               in_ready_d, out_valid_d;
  logic [DATA_W-1:0]  out_data_d;
  logic               out_ovf_d, out_trunc_d, out_fault_d;
  logic [CNT_W-1:0]   out_count_d;
  logic               accept_c;
  logic [DATA_W-1:0]  step_data;
  logic               step_ovf;
  logic               mismatch_c;

  assign accept_c  = in_valid && in_ready;
  assign count_inc = count_q + CNT_W'(1);

  addr8s_sat_step #(.DATA_W(DATA_W), .ALT(1'b0)) u_step (
    .a   (acc_q),
    .b   (in_data),
    .sat (step_data),
    .ovf (step_ovf)
  );

`ifdef ADDR8S_FAULT_CHK_EN
  logic [DATA_W-1:0] chk_sat;
  logic              chk_ovf;

  addr8s_sat_step #(.DATA_W(DATA_W), .ALT(1'b1)) u_step_chk (
    .a   (acc_q),
    .b   (in_data),
    .sat (chk_sat),
    .ovf (chk_ovf)
  );

  assign mismatch_c = ({chk_sat, chk_ovf} != {step_data, step_ovf});
`else
  assign mismatch_c = 1'b0;
`endif

  // Next-state, datapath and output capture.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    fault_d     = fault_q;
    out_data_d  = out_data;
    out_ovf_d   = out_ovf;
    out_trunc_d = out_trunc;
    out_count_d = out_count;
    out_fault_d = out_fault;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          acc_d   = in_data;
          count_d = CNT_W'(1);
          ovf_d   = 1'b0;
          fault_d = 1'b0;
          if (in_last || (MAX_LEN == 1)) begin
            state_d     = HOLD;
            out_data_d  = in_data;
            out_ovf_d   = 1'b0;
            out_trunc_d = !in_last;
            out_count_d = CNT_W'(1);
            out_fault_d = 1'b0;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (accept_c) begin
          acc_d   = step_data;
          count_d = count_inc;
          ovf_d   = ovf_q | step_ovf;
          fault_d = fault_q | mismatch_c;
          if (in_last || (count_inc == CNT_W'(MAX_LEN))) begin
            state_d     = HOLD;
            out_data_d  = step_data;
            out_ovf_d   = ovf_q | step_ovf;
            out_trunc_d = !in_last;
            out_count_d = count_inc;
            out_fault_d = fault_q | mismatch_c;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      fault_q   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
      out_count <= '0;
      out_fault <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      fault_q   <= fault_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_ovf   <= out_ovf_d;
      out_trunc <= out_trunc_d;
      out_count <= out_count_d;
      out_fault <= out_fault_d;
    end
  end

endmodule

// File: tb/tb_addr8s_sat_accum.sv
// Self-checking bench for addr8s_sat_accum: directed bursts with a scoreboard of burst results.
module tb_addr8s_sat_accum;

  localparam int MAX_LEN = 15;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;
  logic       out_trunc;
  logic [7:0] out_count;
  logic       out_fault;

  addr8s_sat_accum #(.DATA_W(8), .MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_trunc (out_trunc),
    .out_count (out_count),
    .out_fault (out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       ovf;
    logic       trunc;
    logic [7:0] count;
    logic       fault;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int   m_acc = 0;
  int   m_cnt = 0;
  logic m_ovf = 1'b0;
  logic m_fault = 1'b0;
  bit   m_inject = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input int d, input logic l);
    int   s;
    exp_t e;
    if (m_cnt == 0) begin
      m_acc   = d;
      m_ovf   = 1'b0;
      m_fault = 1'b0;
      m_cnt   = 1;
    end else begin
      s = m_acc + d;
      if (s > 127) begin
        m_acc = 127;
        m_ovf = 1'b1;
      end else if (s < -128) begin
        m_acc = -128;
        m_ovf = 1'b1;
      end else begin
        m_acc = s;
      end
      m_cnt++;
      m_fault = m_fault | m_inject;
    end
    if (l || m_cnt == MAX_LEN) begin
      e.data  = 8'(m_acc);
      e.ovf   = m_ovf;
      e.trunc = !l;
      e.count = 8'(m_cnt);
      e.fault = m_fault;
      q.push_back(e);
      m_cnt = 0;
    end
  endtask

  // Offer one beat and wait (bounded) for it to be accepted.
  task automatic beat(input int d, input logic l);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'(d);
    in_last  = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    if (ok) model_accept(d, l);
    else chk("beat_accept_timeout", 32'(ok), 32'(1));
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    chk("drain_queue_empty", 32'(q.size()), 32'(0));
  endtask

  // Result monitor: compares each handshaken result against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'(q.size()), 32'(1));
      end else begin
        e = q.pop_front();
        chk("out_data",  32'(out_data),  32'(e.data));
        chk("out_ovf",   32'(out_ovf),   32'(e.ovf));
        chk("out_trunc", 32'(out_trunc), 32'(e.trunc));
        chk("out_count", 32'(out_count), 32'(e.count));
        chk("out_fault", 32'(out_fault), 32'(e.fault));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready",  32'(in_ready),  32'(1));
    chk("rst_out_data",  32'(out_data),  32'(0));
    chk("rst_out_ovf",   32'(out_ovf),   32'(0));
    chk("rst_out_trunc", 32'(out_trunc), 32'(0));
    chk("rst_out_count", 32'(out_count), 32'(0));
    chk("rst_out_fault", 32'(out_fault), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain burst with an idle gap inside: 10, 20, -5 -> 25
    beat(10, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    beat(20, 1'b0);
    chk("mid_burst_no_valid", 32'(out_valid), 32'(0));
    beat(-5, 1'b1);
    chk("latency_out_valid", 32'(out_valid), 32'(1));
    chk("hold_in_ready", 32'(in_ready), 32'(0));
    drain();

    // Positive clamp mid-burst: 100, 100 -> 127, then -50 -> 77
    beat(100, 1'b0);
    beat(100, 1'b0);
    beat(-50, 1'b1);
    drain();

    // Negative clamp: -100, -100 -> -128
    beat(-100, 1'b0);
    beat(-100, 1'b1);
    drain();

    // MAX_LEN forced termination, then the 16th beat opens a new burst
    for (int i = 0; i < MAX_LEN; i++) beat(1, 1'b0);
    chk("maxlen_out_valid", 32'(out_valid), 32'(1));
    chk("maxlen_in_ready",  32'(in_ready),  32'(0));
    beat(1, 1'b0);
    beat(2, 1'b1);
    drain();

    // in_last on the MAX_LEN beat is not a truncation
    for (int i = 0; i < MAX_LEN - 1; i++) beat(1, 1'b0);
    beat(1, 1'b1);
    drain();

    // Backpressure: result held stable, input blocked
    out_ready = 1'b0;
    beat(5, 1'b0);
    beat(6, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready",  32'(in_ready),  32'(0));
      chk("bp_out_valid", 32'(out_valid), 32'(1));
      chk("bp_out_data",  32'(out_data),  32'(11));
      chk("bp_out_count", 32'(out_count), 32'(2));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready",  32'(in_ready),  32'(1));
    chk("bp_release_out_valid", 32'(out_valid), 32'(0));
    drain();

    // Reset mid-burst discards the partial sum
    beat(3, 1'b0);
    beat(4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    m_cnt = 0;
    chk("midrst_out_data",  32'(out_data),  32'(0));
    chk("midrst_out_count", 32'(out_count), 32'(0));
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_in_ready",  32'(in_ready),  32'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(7, 1'b1);
    drain();

`ifdef ADDR8S_FAULT_CHK_EN
    // Corrupt the check adder on one accepted ACC beat; only that burst flags a fault
    beat(1, 1'b0);
    m_inject = 1'b1;
    force dut.chk_sat = 8'h00;
    beat(2, 1'b1);
    release dut.chk_sat;
    m_inject = 1'b0;
    drain();
    beat(4, 1'b0);
    beat(5, 1'b1);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
